airlock_sequencer: RTL and testbench
====================================

Name: airlock_sequencer

Overview:
- Automatic command sequencer sitting directly upstream of the airlock datapath (outer door, inner door, pressurizer, bathysphere mover).
- Replaces the manual switch/key operation of those stages. It turns one-cycle arrive/depart requests into an interlocked series of door requests and pressurize/depressurize strobes.
- Each step waits on status fed back from the downstream stages, with a per-step watchdog.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in any wait state before entering FAULT.
- SETTLE_CYCLES, 4, idle cycles inserted after every strobe or door-request change before status is sampled.
- CNT_W, 8, width of the shared step counter; must satisfy 2^CNT_W > max(TIMEOUT_CYCLES, SETTLE_CYCLES).

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (driven from KEY[0]).
- arrive  input  1  one-cycle request: bathysphere wants to dock.
- depart  input  1  one-cycle request: bathysphere wants to leave.
- outer_open  input  1  status: outer door fully open.
- inner_open  input  1  status: inner door fully open.
- pressurized  input  1  status: 1 = chamber at cabin pressure, 0 = chamber at sea pressure.
- docked  input  1  status: bathysphere in the chamber.
- outer_req  output  1  level: request outer door open.
- inner_req  output  1  level: request inner door open.
- press_stb  output  1  one-cycle strobe: start pressurize.
- depress_stb  output  1  one-cycle strobe: start depressurize.
- busy  output  1  high in every state except IDLE, DOCKED, FAULT.
- fault  output  1  sticky watchdog or interlock fault.

Behaviour:
- Outputs: all registered. Reset (reset==0 at a clock edge) forces state IDLE, counter 0, and all outputs 0. This holds from any state, including mid-sequence and FAULT.
- Strobes: press_stb and depress_stb are high for exactly one cycle, on the cycle after the state entering the corresponding step is registered. They are never both high.
- Settle and wait: after each strobe or request change, the counter runs SETTLE_CYCLES cycles. The counter then clears and counts wait cycles. The state advances on the first edge where the awaited status is true. If the count reaches TIMEOUT_CYCLES, the state goes to FAULT.
- Arrival path, accepted only in IDLE:
  - A_DEPRESS: depress_stb, wait pressurized==0.
  - A_OPEN_O: outer_req=1, wait outer_open.
  - A_DOCK: wait docked. No timeout in this state; aborted only by reset.
  - A_CLOSE_O: outer_req=0, wait !outer_open.
  - A_PRESS: press_stb, wait pressurized.
  - A_OPEN_I: inner_req=1, wait inner_open.
  - DOCKED: inner_req held 1.
- Departure path, accepted only in DOCKED:
  - D_CLOSE_I: inner_req=0, wait !inner_open.
  - D_DEPRESS: depress_stb, wait pressurized==0.
  - D_OPEN_O: outer_req=1, wait outer_open.
  - D_UNDOCK: wait !docked. No timeout in this state.
  - D_CLOSE_O: outer_req=0, wait !outer_open.
  - D_PRESS: press_stb, wait pressurized.
  - IDLE.
- Request filtering:
  - arrive in any state other than IDLE is ignored.
  - depart in any state other than DOCKED is ignored.
  - arrive and depart in the same cycle: only the one legal for the current state is taken.
- Interlocks, checked every cycle. The next state is FAULT if either of these holds:
  - outer_req would be 1 while inner_open==1 or pressurized==1 (outside the settle window following that step's strobe).
  - inner_req would be 1 while outer_open==1 or pressurized==0.
- FAULT: outer_req=0, inner_req=0, no strobes, busy=0, fault=1. Left only by reset.
- Counter: saturates and never wraps. It is cleared on every state change.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arrive=1 → all outputs 0, state IDLE; release → still IDLE, no strobe.
- Full arrival: arrive pulse, model returns each status 3 cycles after its request → depress_stb 1 cycle, outer_req rises then falls, press_stb 1 cycle, inner_req=1, busy=0 in DOCKED; total strobes: exactly one of each.
- Full departure from DOCKED: depart pulse → inner_req drops, depress_stb, outer_req up/down after docked falls, press_stb, return to IDLE with all outputs 0.
- Timeout: arrival with pressurized stuck at 1 → FAULT after SETTLE_CYCLES+TIMEOUT_CYCLES (4+16=20) cycles past depress_stb; fault=1, outer_req never asserted.
- Interlock: in DOCKED force outer_open=1 → next cycle fault=1, inner_req=0.
- Ignored and mid-op reset: depart in IDLE → no activity. arrive during A_OPEN_O → ignored. reset=0 during A_PRESS → IDLE next edge, outputs 0.

Source files
------------

// File: rtl/airlock_sequencer_if.sv
// Request/status bundle between the airlock sequencer and the door, pressure and mover stages.
// The sequencer takes the master side; the downstream datapath (or a bench) takes the slave side.
interface airlock_sequencer_if;
  logic arrive;
  logic depart;
  logic outer_open;
  logic inner_open;
  logic pressurized;
  logic docked;
  logic outer_req;
  logic inner_req;
  logic press_stb;
  logic depress_stb;
  logic busy;
  logic fault;

  modport master (
    input  arrive, depart, outer_open, inner_open, pressurized, docked,
    output outer_req, inner_req, press_stb, depress_stb, busy, fault
  );

  modport slave (
    output arrive, depart, outer_open, inner_open, pressurized, docked,
    input  outer_req, inner_req, press_stb, depress_stb, busy, fault
  );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock command sequencer: turns arrive/depart pulses into interlocked door requests and
// pressure strobes, stepping on downstream status with a settle window and per-step watchdog.
module airlock_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_W          = 8
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  airlock_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StADepress, StAOpenO, StADock, StACloseO, StAPress, StAOpenI, StDocked,
    StDCloseI, StDDepress, StDOpenO, StDUndock, StDCloseO, StDPress, StFault
  } state_e;

  localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d, step_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             settle_q, settle_d;
  logic             first_q, first_d;
  logic             wait_ok, has_timeout, outer_cmd, inner_cmd, ilock;
  logic             outer_req_q, inner_req_q, press_stb_q, depress_stb_q, busy_q, fault_q;

  // Steps with no command change (docking, undocking, parked states) sample status immediately.
  function automatic logic settles(state_e s);
    return !(s inside {StIdle, StADock, StDocked, StDUndock, StFault});
  endfunction

  always_comb begin
    wait_ok     = 1'b0;
    has_timeout = 1'b1;
    outer_cmd   = 1'b0;
    inner_cmd   = 1'b0;
    step_next   = StIdle;
    case (state_q)
      StADepress: begin wait_ok = !bus.pressurized; step_next = StAOpenO; end
      StAOpenO:   begin outer_cmd = 1'b1; wait_ok = bus.outer_open; step_next = StADock; end
      StADock: begin
        outer_cmd   = 1'b1;
        has_timeout = 1'b0;
        wait_ok     = bus.docked;
        step_next   = StACloseO;
      end
      StACloseO:  begin wait_ok = !bus.outer_open; step_next = StAPress; end
      StAPress:   begin wait_ok = bus.pressurized; step_next = StAOpenI; end
      StAOpenI:   begin inner_cmd = 1'b1; wait_ok = bus.inner_open; step_next = StDocked; end
      StDocked:   begin inner_cmd = 1'b1; has_timeout = 1'b0; end
      StDCloseI:  begin wait_ok = !bus.inner_open; step_next = StDDepress; end
      StDDepress: begin wait_ok = !bus.pressurized; step_next = StDOpenO; end
      StDOpenO:   begin outer_cmd = 1'b1; wait_ok = bus.outer_open; step_next = StDUndock; end
      StDUndock: begin
        outer_cmd   = 1'b1;
        has_timeout = 1'b0;
        wait_ok     = !bus.docked;
        step_next   = StDCloseO;
      end
      StDCloseO:  begin wait_ok = !bus.outer_open; step_next = StDPress; end
      StDPress:   begin wait_ok = bus.pressurized; step_next = StIdle; end
      default:    has_timeout = 1'b0;
    endcase
  end

  // Interlocks are ignored while the step's own settle window is still running.
  assign ilock = !settle_q &&
                 ((outer_cmd && (bus.inner_open || bus.pressurized)) ||
                  (inner_cmd && (bus.outer_open || !bus.pressurized)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    first_d  = 1'b0;
    if (ilock) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StIdle:   if (bus.arrive) state_d = StADepress;
        StDocked: if (bus.depart) state_d = StDCloseI;
        StFault:  state_d = StFault;
        default: begin
          if (settle_q) begin
            if (cnt_q == SettleLast) begin
              settle_d = 1'b0;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (wait_ok) begin
            state_d = step_next;
          end else if (has_timeout && (cnt_q == TimeoutLast)) begin
            state_d = StFault;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
    if (state_d != state_q) begin
      cnt_d    = '0;
      first_d  = 1'b1;
      settle_d = settles(state_d) && (SETTLE_CYCLES != 0);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      settle_q      <= 1'b0;
      first_q       <= 1'b0;
      outer_req_q   <= 1'b0;
      inner_req_q   <= 1'b0;
      press_stb_q   <= 1'b0;
      depress_stb_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      settle_q      <= settle_d;
      first_q       <= first_d;
      outer_req_q   <= outer_cmd;
      inner_req_q   <= inner_cmd;
      press_stb_q   <= first_q && ((state_q == StAPress) || (state_q == StDPress));
      depress_stb_q <= first_q && ((state_q == StADepress) || (state_q == StDDepress));
      busy_q        <= !((state_q == StIdle) || (state_q == StDocked) || (state_q == StFault));
      fault_q       <= (state_q == StFault);
    end
  end

  assign bus.outer_req   = outer_req_q;
  assign bus.inner_req   = inner_req_q;
  assign bus.press_stb   = press_stb_q;
  assign bus.depress_stb = depress_stb_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: a delayed-response airlock plant plus a table-driven step model
// that predicts every registered output each cycle under directed and random stimulus.
module tb_airlock_sequencer;
  localparam int TIMEOUT = 16;
  localparam int SETTLE  = 4;
  localparam int SIdle = 0, SAOpenO = 2, SAPress = 5, SDocked = 7, SFault = 14;

  logic clk = 1'b0;
  logic reset;
  airlock_sequencer_if bus ();

  airlock_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (8)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int m_step = SIdle, m_age = 0;
  logic e_outer = 0, e_inner = 0, e_press = 0, e_depress = 0, e_busy = 0, e_fault = 0;
  logic p_outer = 0, p_inner = 0, p_press = 1, p_docked = 0, press_tgt = 1, want_dock = 0;
  int t_outer = 0, t_inner = 0, t_press = 0, t_docked = 0, dly = 3;
  bit press_stuck = 0, force_outer = 0, seen_outer = 0;
  int n_press = 0, n_depress = 0, depress_cyc = -1, fault_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Step table: 0 idle, 1-6 arrival steps, 7 docked, 8-13 departure steps, 14 fault.
  function automatic logic is_outer(int s);
    return (s == 2) || (s == 3) || (s == 10) || (s == 11);
  endfunction
  function automatic logic is_inner(int s);
    return (s == 6) || (s == 7);
  endfunction
  function automatic logic has_settle(int s);
    return (s inside {1, 2, 4, 5, 6, 8, 9, 10, 12, 13});
  endfunction
  function automatic logic awaited(int s);
    case (s)
      1, 9:   return !bus.pressurized;
      2, 10:  return bus.outer_open;
      3:      return bus.docked;
      4, 12:  return !bus.outer_open;
      5, 13:  return bus.pressurized;
      6:      return bus.inner_open;
      8:      return !bus.inner_open;
      11:     return !bus.docked;
      default: return 1'b0;
    endcase
  endfunction

  // Advances the model across one clock edge using the inputs about to be sampled.
  task automatic model_step();
    int nxt, win;
    logic ilock;
    if (!reset) begin
      m_step = SIdle; m_age = 0;
      {e_outer, e_inner, e_press, e_depress, e_busy, e_fault} = '0;
      return;
    end
    e_outer   = is_outer(m_step);
    e_inner   = is_inner(m_step);
    e_press   = ((m_step == 5) || (m_step == 13)) && (m_age == 0);
    e_depress = ((m_step == 1) || (m_step == 9)) && (m_age == 0);
    e_busy    = (m_step != SIdle) && (m_step != SDocked) && (m_step != SFault);
    e_fault   = (m_step == SFault);
    win   = has_settle(m_step) ? SETTLE : 0;
    ilock = (m_age >= win) &&
            ((is_outer(m_step) && (bus.inner_open || bus.pressurized)) ||
             (is_inner(m_step) && (bus.outer_open || !bus.pressurized)));
    nxt = m_step;
    if (ilock) nxt = SFault;
    else if (m_step == SIdle) begin if (bus.arrive) nxt = 1; end
    else if (m_step == SDocked) begin if (bus.depart) nxt = 8; end
    else if (m_step == SFault || m_age < win) nxt = m_step;
    else if (awaited(m_step)) nxt = (m_step == 13) ? SIdle : m_step + 1;
    else if (has_settle(m_step) && (m_age - win + 1 >= TIMEOUT)) nxt = SFault;
    if (nxt != m_step) begin m_step = nxt; m_age = 0; end
    else m_age++;
  endtask

  task automatic follow(inout logic cur, inout int tmr, input logic tgt);
    if (cur === tgt) tmr = 0;
    else begin
      if (tmr == 0) tmr = dly;
      tmr--;
      if (tmr == 0) cur = tgt;
    end
  endtask

  task automatic drive_status();
    bus.outer_open  = p_outer | force_outer;
    bus.inner_open  = p_inner;
    bus.pressurized = p_press;
    bus.docked      = p_docked;
  endtask

  task automatic tick(input logic arr, input logic dep, input logic rst);
    @(negedge clk);
    cyc++;
    check_eq("outer_req", bus.outer_req, e_outer);
    check_eq("inner_req", bus.inner_req, e_inner);
    check_eq("press_stb", bus.press_stb, e_press);
    check_eq("depress_stb", bus.depress_stb, e_depress);
    check_eq("busy", bus.busy, e_busy);
    check_eq("fault", bus.fault, e_fault);
    if (bus.press_stb) n_press++;
    if (bus.depress_stb) begin n_depress++; depress_cyc = cyc; end
    if (bus.outer_req) seen_outer = 1;
    if (bus.fault && fault_cyc < 0) fault_cyc = cyc;
    if (bus.press_stb) press_tgt = 1'b1;
    if (bus.depress_stb) press_tgt = 1'b0;
    if (!press_stuck) follow(p_press, t_press, press_tgt);
    follow(p_outer, t_outer, bus.outer_req);
    follow(p_inner, t_inner, bus.inner_req);
    if (p_outer) follow(p_docked, t_docked, want_dock);
    drive_status();
    bus.arrive = arr;
    bus.depart = dep;
    reset      = rst;
    model_step();
  endtask

  task automatic run_to(input int target, input int budget, input string tag);
    int n = 0;
    while (m_step != target && n < budget) begin tick(0, 0, 1); n++; end
    check_eq(tag, m_step, target);
  endtask

  task automatic do_reset();
    tick(0, 0, 0);
    tick(0, 0, 1);
  endtask

  initial begin
    logic arr, dep, rst;
    int frun;
    reset = 1'b0; bus.arrive = 1'b1; bus.depart = 1'b0;
    drive_status();
    // Reset held with arrive asserted, then released.
    tick(1, 0, 0);
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 1);
    check_eq("rst_idle_busy", bus.busy, 0);
    check_eq("rst_idle_depress", n_depress, 0);

    // Full arrival, statuses follow 3 cycles behind each request.
    n_press = 0; n_depress = 0; want_dock = 1;
    tick(1, 0, 1);
    run_to(SDocked, 400, "arr_reach_docked");
    repeat (3) tick(0, 0, 1);
    check_eq("arr_inner_req", bus.inner_req, 1);
    check_eq("arr_busy", bus.busy, 0);
    check_eq("arr_n_press", n_press, 1);
    check_eq("arr_n_depress", n_depress, 1);

    // Full departure back to idle.
    n_press = 0; n_depress = 0; want_dock = 0;
    tick(0, 1, 1);
    run_to(SIdle, 400, "dep_reach_idle");
    repeat (3) tick(0, 0, 1);
    check_eq("dep_outer", bus.outer_req, 0);
    check_eq("dep_inner", bus.inner_req, 0);
    check_eq("dep_n_press", n_press, 1);
    check_eq("dep_n_depress", n_depress, 1);

    // depart while idle does nothing.
    tick(0, 1, 1);
    repeat (3) tick(0, 0, 1);
    check_eq("idle_depart_busy", bus.busy, 0);

    // Watchdog: chamber never depressurizes.
    press_stuck = 1; seen_outer = 0; fault_cyc = -1; depress_cyc = -1; want_dock = 1;
    tick(1, 0, 1);
    for (int i = 0; i < 60 && fault_cyc < 0; i++) tick(0, 0, 1);
    check_eq("tmo_fault", bus.fault, 1);
    check_eq("tmo_latency", fault_cyc - depress_cyc, SETTLE + TIMEOUT);
    check_eq("tmo_no_outer", seen_outer, 0);
    press_stuck = 0;
    do_reset();

    // Interlock: outer door reports open while docked.
    tick(1, 0, 1);
    run_to(SDocked, 400, "ilk_reach_docked");
    tick(0, 0, 1);
    force_outer = 1;
    tick(0, 0, 1);
    force_outer = 0;
    tick(0, 0, 1);
    tick(0, 0, 1);
    check_eq("ilk_fault", bus.fault, 1);
    check_eq("ilk_inner", bus.inner_req, 0);
    do_reset();

    // Stray arrive mid-sequence, then reset during pressurize.
    want_dock = 0;
    run_to(SIdle, 200, "mid_idle");
    tick(0, 0, 1);
    want_dock = 1;
    tick(1, 0, 1);
    run_to(SAOpenO, 200, "mid_reach_open_o");
    tick(1, 0, 1);
    run_to(SAPress, 400, "mid_reach_press");
    tick(0, 0, 1);
    do_reset();
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_press", bus.press_stb, 0);

    // Random traffic, random plant latency, occasional resets.
    for (int it = 0; it < 40; it++) begin
      dly = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 22) : $urandom_range(1, 6);
      frun = 0;
      repeat ($urandom_range(30, 150)) begin
        arr = ($urandom_range(0, 14) == 0);
        dep = ($urandom_range(0, 14) == 0);
        rst = ($urandom_range(0, 199) != 0);
        frun = (m_step == SFault) ? frun + 1 : 0;
        if (frun > 3) rst = 1'b0;
        if (arr && m_step == SIdle) want_dock = 1;
        if (dep && m_step == SDocked) want_dock = 0;
        tick(arr, dep, rst);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
